// File: rtl/seq_cmd_arbiter_if.sv
// Command/handshake bundle between requesters, sequencer and seq_cmd_arbiter.
// The master side drives requests, commands and sequencer status;
// the slave side (the arbiter) drives controls, grant and status.
interface seq_cmd_arbiter_if;
  logic [1:0] req;
  logic [1:0] cmd0;
  logic [1:0] cmd1;
  logic [3:0] arg0;
  logic [3:0] arg1;
  logic       abort;
  logic       terminal;
  logic       restart;
  logic       pause;
  logic       go_to_third;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] lap_count;

  modport master (
    output req, cmd0, cmd1, arg0, arg1, abort, terminal,
    input  restart, pause, go_to_third, gnt, busy, done, err, lap_count
  );

  modport slave (
    input  req, cmd0, cmd1, arg0, arg1, abort, terminal,
    output restart, pause, go_to_third, gnt, busy, done, err, lap_count
  );
endinterface

// File: rtl/seq_cmd_arbiter.sv
// Two-requester round-robin command arbiter driving sequencer controls.
//
// state       | meaning
// ------------+------------------------------------------------------
// S_IDLE      | no command; requests sampled and arbitrated
// S_RESTART   | restart pulse to sequencer (one cycle)
// S_PAUSE     | pause held for arg+1 cycles
// S_WAIT_TERM | LOOP command waiting for terminal, 16-cycle timeout
// S_LOOP      | go_to_third pulse (one cycle)
// S_RUN       | counting terminal rising edges up to arg+1
// S_DONE      | one-cycle completion, done/err valid, grant still held
module seq_cmd_arbiter (
  input logic           clk,
  input logic           reset,
  seq_cmd_arbiter_if.slave bus
);

  localparam logic [1:0] CMD_RESTART = 2'b00;
  localparam logic [1:0] CMD_PAUSE   = 2'b01;
  localparam logic [1:0] CMD_LOOP    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_RESTART, S_PAUSE, S_WAIT_TERM, S_LOOP, S_RUN, S_DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last_gnt;
  logic       term_q;
  logic       restart_q;
  logic       pause_q;
  logic       gtt_q;
  logic [1:0] gnt_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [7:0] lap_q;

  logic       term_rise;
  logic       pick;
  logic [1:0] cmd_sel;
  logic [3:0] arg_sel;

  assign term_rise = bus.terminal & ~term_q;

  // Round-robin pick: on a tie serve whoever was not granted last.
  always_comb begin
    pick    = (bus.req == 2'b11) ? ~last_gnt : bus.req[1];
    cmd_sel = pick ? bus.cmd1 : bus.cmd0;
    arg_sel = pick ? bus.arg1 : bus.arg0;
  end

  // Command FSM with registered controls, grant and completion status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      last_gnt  <= 1'b1;
      restart_q <= 1'b0;
      pause_q   <= 1'b0;
      gtt_q     <= 1'b0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            gnt_q    <= pick ? 2'b10 : 2'b01;
            busy_q   <= 1'b1;
            last_gnt <= pick;
            case (cmd_sel)
              CMD_RESTART: begin
                state     <= S_RESTART;
                restart_q <= 1'b1;
              end
              CMD_PAUSE: begin
                state   <= S_PAUSE;
                pause_q <= 1'b1;
                cnt     <= arg_sel;
              end
              CMD_LOOP: begin
                state <= S_WAIT_TERM;
                cnt   <= 4'd15;
              end
              default: begin
                state <= S_RUN;
                cnt   <= arg_sel;
              end
            endcase
          end
        end
        S_RESTART: begin
          state     <= S_DONE;
          done_q    <= 1'b1;
          err_q     <= bus.abort;
          restart_q <= 1'b0;
        end
        S_PAUSE: begin
          if (bus.abort || cnt == 4'd0) begin
            state   <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= bus.abort;
            pause_q <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_WAIT_TERM: begin
          if (bus.abort) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else if (bus.terminal) begin
            state <= S_LOOP;
            gtt_q <= 1'b1;
          end else if (cnt == 4'd0) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_LOOP: begin
          state  <= S_DONE;
          done_q <= 1'b1;
          err_q  <= bus.abort;
          gtt_q  <= 1'b0;
        end
        S_RUN: begin
          if (bus.abort) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else if (term_rise) begin
            if (cnt == 4'd0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          gnt_q  <= 2'b00;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Terminal history and saturating lap counter; a clean RESTART clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      term_q <= 1'b0;
      lap_q  <= 8'd0;
    end else begin
      term_q <= bus.terminal;
      if (state == S_RESTART && !bus.abort)
        lap_q <= 8'd0;
      else if (term_rise && lap_q != 8'd255)
        lap_q <= lap_q + 8'd1;
    end
  end

  assign bus.restart     = restart_q;
  assign bus.pause       = pause_q;
  assign bus.go_to_third = gtt_q;
  assign bus.gnt         = gnt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.lap_count   = lap_q;

endmodule
